// File: rtl/ssd_scan_ctrl.sv
// Time-multiplexed scan controller for an N-digit common-anode seven-segment display.
// Walks one digit per slot with anti-ghost blanking, leading-zero suppression, blink and tear-free updates.
module ssd_scan_ctrl #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 100000,
  parameter int BLANK_CYC = 1000,
  parameter int BLINK_DIV = 50
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    enable,
  input  logic [4*N_DIGITS-1:0]   digits_in,
  input  logic                    upd_req,
  output logic                    upd_ack,
  input  logic [N_DIGITS-1:0]     blink_mask,
  input  logic                    lz_suppress,
  output logic [3:0]              ssd_bcd,
  output logic [N_DIGITS-1:0]     ssd_an,
  output logic                    frame_tick
);

  localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam int BLK_W  = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

  localparam logic [SLOT_W-1:0] SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0] SLOT_BLANK = SLOT_W'(BLANK_CYC);
  localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(N_DIGITS - 1);
  localparam logic [BLK_W-1:0]  BLK_LAST   = BLK_W'(BLINK_DIV - 1);

  logic [SLOT_W-1:0]     slot_cnt;
  logic [IDX_W-1:0]      digit_idx;
  logic [BLK_W-1:0]      blink_cnt;
  logic                  blink_phase;
  logic [4*N_DIGITS-1:0] shadow;

  logic                  slot_wrap;
  logic                  fb;
  logic                  in_blank;
  logic                  zero_run;
  logic [N_DIGITS-1:0]   lz_blank;
  logic [N_DIGITS-1:0]   an_sel;
  logic [3:0]            eff_code;

  assign slot_wrap = (slot_cnt == SLOT_LAST);
  assign fb        = slot_wrap && (digit_idx == IDX_LAST);
  assign in_blank  = (slot_cnt < SLOT_BLANK);

  // A digit is a leading zero when it and every more significant digit are zero.
  always_comb begin
    zero_run = 1'b1;
    lz_blank = '0;
    for (int i = N_DIGITS - 1; i >= 0; i--) begin
      zero_run    = zero_run & (shadow[4*i +: 4] == 4'd0);
      lz_blank[i] = lz_suppress & zero_run & (i != 0);
    end
  end

  always_comb begin
    eff_code = 4'd15;
    an_sel   = '1;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digit_idx == IDX_W'(i)) begin
        an_sel[i] = 1'b0;
        if (blink_mask[i] && blink_phase)
          eff_code = 4'd15;
        else if (lz_blank[i])
          eff_code = 4'd15;
        else
          eff_code = shadow[4*i +: 4];
      end
    end
  end

  // Update handshake: upd_req is a level request that must hold with digits_in stable;
  // the shadow is loaded on a frame boundary (or any edge while disabled) and upd_ack
  // pulses the following cycle to say that load happened.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt    <= '0;
      digit_idx   <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      shadow      <= '1;
      ssd_bcd     <= 4'd15;
      ssd_an      <= '1;
      upd_ack     <= 1'b0;
      frame_tick  <= 1'b0;
    end else if (!enable) begin
      slot_cnt   <= '0;
      digit_idx  <= '0;
      ssd_bcd    <= 4'd15;
      ssd_an     <= '1;
      frame_tick <= 1'b0;
      upd_ack    <= upd_req;
      if (upd_req)
        shadow <= digits_in;
    end else begin
      slot_cnt <= slot_wrap ? '0 : slot_cnt + SLOT_W'(1);
      if (slot_wrap)
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + IDX_W'(1);
      frame_tick <= fb;
      upd_ack    <= fb && upd_req;
      if (fb && upd_req)
        shadow <= digits_in;
      if (fb) begin
        if (blink_cnt == BLK_LAST) begin
          blink_cnt   <= '0;
          blink_phase <= ~blink_phase;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
      // Anodes stay dark at the start of each slot so the previous digit cannot ghost.
      if (in_blank) begin
        ssd_an  <= '1;
        ssd_bcd <= 4'd15;
      end else begin
        ssd_an  <= an_sel;
        ssd_bcd <= eff_code;
      end
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Bench for ssd_scan_ctrl: table of display scenarios, hand sequences for scan corners,
// then random traffic against a frame/position based reference model.
module tb_ssd_scan_ctrl;

  localparam int N  = 4;
  localparam int SD = 8;
  localparam int BC = 2;
  localparam int BD = 2;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         enable = 1'b0;
  logic [15:0]  digits_in = '0;
  logic         upd_req = 1'b0;
  logic         upd_ack;
  logic [3:0]   blink_mask = '0;
  logic         lz_suppress = 1'b0;
  logic [3:0]   ssd_bcd;
  logic [3:0]   ssd_an;
  logic         frame_tick;

  ssd_scan_ctrl #(.N_DIGITS(N), .SCAN_DIV(SD), .BLANK_CYC(BC), .BLINK_DIV(BD)) dut (
    .clk(clk), .rst(rst), .enable(enable), .digits_in(digits_in),
    .upd_req(upd_req), .upd_ack(upd_ack), .blink_mask(blink_mask),
    .lz_suppress(lz_suppress), .ssd_bcd(ssd_bcd), .ssd_an(ssd_an),
    .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: position within the scan since it (re)started, frames completed, shadow.
  int         scan_pos = 0;
  int         frames_done = 0;
  logic [3:0] m_shadow [N];

  typedef struct {
    logic [15:0] code;
    logic        lz;
    logic [3:0]  mask;
    logic [15:0] exp;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [3:0] model_eff(input int i);
    bit phase;
    bit all_zero;
    phase = ((frames_done / BD) % 2) == 1;
    all_zero = 1'b1;
    for (int j = i; j < N; j++)
      if (m_shadow[j] != 4'd0) all_zero = 1'b0;
    if (blink_mask[i] && phase) return 4'hF;
    if (lz_suppress && i != 0 && all_zero) return 4'hF;
    return m_shadow[i];
  endfunction

  task automatic model_reset();
    scan_pos = 0;
    frames_done = 0;
    for (int i = 0; i < N; i++) m_shadow[i] = 4'hF;
  endtask

  // One clock: predict from model + current inputs, clock, compare, advance the model.
  task automatic step();
    logic [3:0]  e_an, e_bcd;
    logic        e_tick, e_ack;
    logic [15:0] d_snap;
    bit          fb;
    int          slot, dig;
    slot = scan_pos % SD;
    dig  = (scan_pos / SD) % N;
    fb   = (scan_pos % (SD * N)) == (SD * N - 1);
    d_snap = digits_in;
    if (enable) begin
      if (slot < BC) begin
        e_an = 4'hF; e_bcd = 4'hF;
      end else begin
        e_an  = 4'hF ^ (4'(1) << dig);
        e_bcd = model_eff(dig);
      end
      e_tick = fb;
      e_ack  = fb && upd_req;
    end else begin
      e_an = 4'hF; e_bcd = 4'hF; e_tick = 1'b0; e_ack = upd_req;
    end
    @(posedge clk); #1;
    check("ssd_an", ssd_an, e_an);
    check("ssd_bcd", ssd_bcd, e_bcd);
    check("frame_tick", frame_tick, e_tick);
    check("upd_ack", upd_ack, e_ack);
    if (enable) begin
      scan_pos++;
      if (fb) frames_done++;
    end else begin
      scan_pos = 0;
    end
    if (e_ack)
      for (int i = 0; i < N; i++) m_shadow[i] = d_snap[4*i +: 4];
  endtask

  // Asynchronous reset asserted between edges; outputs must settle before any clock.
  task automatic async_reset();
    #2 rst = 1'b1;
    #1;
    check("rst_an", ssd_an, 4'hF);
    check("rst_bcd", ssd_bcd, 4'hF);
    check("rst_ack", upd_ack, 1'b0);
    check("rst_tick", frame_tick, 1'b0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic load_disabled(input logic [15:0] code);
    enable = 1'b0; upd_req = 1'b1; digits_in = code;
    step();
    upd_req = 1'b0;
  endtask

  initial begin
    logic [15:0] e;
    bit acked;
    tbl[0] = '{16'h0050, 1'b1, 4'b0000, 16'hFF50};
    tbl[1] = '{16'h0000, 1'b1, 4'b0000, 16'hFFF0};
    tbl[2] = '{16'h1234, 1'b1, 4'b0000, 16'h1234};
    tbl[3] = '{16'h0050, 1'b0, 4'b0000, 16'h0050};
    tbl[4] = '{16'h0102, 1'b1, 4'b0000, 16'hF102};
    tbl[5] = '{16'h000F, 1'b1, 4'b0000, 16'hFFFF};
    tbl[6] = '{16'h1234, 1'b0, 4'b1111, 16'h1234};
    tbl[7] = '{16'h9000, 1'b1, 4'b0000, 16'h9000};
    model_reset();

    // T1: blank scan after reset, anode walk and frame_tick period
    async_reset();
    enable = 1'b1;
    for (int c = 0; c < 64; c++) begin
      step();
      check("t1_an", ssd_an, (c % 8 < 2) ? 4'hF : (4'hF ^ (4'(1) << ((c / 8) % 4))));
      check("t1_bcd", ssd_bcd, 4'hF);
      check("t1_tick", frame_tick, (c % 32) == 31);
    end

    // T2: mid-frame update request lands on the frame boundary
    for (int c = 0; c < 10; c++) step();
    digits_in = 16'h1234; upd_req = 1'b1;
    acked = 1'b0;
    for (int c = 0; c < 40 && !acked; c++) begin
      step();
      if (upd_ack) begin
        acked = 1'b1;
        check("t2_ack_with_tick", frame_tick, 1'b1);
      end else begin
        check("t2_no_tear", ssd_bcd, 4'hF);
      end
    end
    if (!acked) check("t2_ack_timeout", 1'b0, 1'b1);
    upd_req = 1'b0;
    for (int c = 0; c < 32; c++) begin
      step();
      if (c % 8 == 4) check("t2_digit", ssd_bcd, 4 - (c / 8));
    end

    // T3 and friends: shadow / suppression / mask scenarios
    for (int k = 0; k < 8; k++) begin
      async_reset();
      lz_suppress = tbl[k].lz;
      blink_mask = tbl[k].mask;
      load_disabled(tbl[k].code);
      enable = 1'b1;
      e = tbl[k].exp;
      for (int c = 0; c < 32; c++) begin
        step();
        if (c % 8 == 4) begin
          check("tbl_bcd", ssd_bcd, e[4*(c/8) +: 4]);
          check("tbl_an", ssd_an, 4'hF ^ (4'(1) << (c / 8)));
        end
      end
    end

    // T4: digit 1 blinks with a two-frame half-period
    async_reset();
    lz_suppress = 1'b0; blink_mask = 4'b0010;
    load_disabled(16'h1234);
    enable = 1'b1;
    for (int c = 0; c < 128; c++) begin
      step();
      if (c % 32 == 12) check("t4_blink", ssd_bcd, (c / 32 < 2) ? 4'd3 : 4'hF);
      if (c % 32 == 4)  check("t4_steady", ssd_bcd, 4'd4);
    end

    // T5: disable mid-slot, load while disabled, restart from digit 0
    blink_mask = 4'b0000;
    for (int c = 0; c < 13; c++) step();
    enable = 1'b0;
    step();
    check("t5_off_an", ssd_an, 4'hF);
    check("t5_off_bcd", ssd_bcd, 4'hF);
    upd_req = 1'b1; digits_in = 16'h5678;
    step();
    check("t5_ack", upd_ack, 1'b1);
    upd_req = 1'b0;
    step();
    check("t5_ack_drop", upd_ack, 1'b0);
    enable = 1'b1;
    step(); check("t5_blank0", ssd_an, 4'hF);
    step(); check("t5_blank1", ssd_an, 4'hF);
    step();
    check("t5_d0_an", ssd_an, 4'hE);
    check("t5_d0_bcd", ssd_bcd, 4'd8);

    // T6: reset mid-frame drops the shadow and restarts the scan
    for (int c = 0; c < 17; c++) step();
    async_reset();
    step(); check("t6_blank0", ssd_an, 4'hF);
    step(); check("t6_blank1", ssd_an, 4'hF);
    step();
    check("t6_d0_an", ssd_an, 4'hE);
    check("t6_d0_bcd", ssd_bcd, 4'hF);

    // Random traffic against the model
    async_reset();
    for (int n = 0; n < 3000; n++) begin
      enable = ($urandom_range(0, 49) != 0);
      upd_req = ($urandom_range(0, 3) == 0);
      for (int i = 0; i < N; i++)
        digits_in[4*i +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      blink_mask = 4'($urandom_range(0, 15));
      lz_suppress = 1'($urandom_range(0, 1));
      step();
      if ($urandom_range(0, 499) == 0) async_reset();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
